// File: rtl/tau_pkg.sv
// Shared definitions for the fetch path and its neighbours.
//   fetch_state_t : flash_fetch FSM states
//   FLASH_ADDR_W  : flash byte-address width
//   INSTR_BYTES   : bytes per instruction
//   PC_*          : program_counter operation encodings
package tau_pkg;

  localparam int FLASH_ADDR_W = 24;
  localparam int INSTR_BYTES  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    DRAIN = 2'b10,
    HOLD  = 2'b11
  } fetch_state_t;

  localparam logic [1:0] PC_HOLD   = 2'b00;
  localparam logic [1:0] PC_INC    = 2'b01;
  localparam logic [1:0] PC_BRANCH = 2'b10;
  localparam logic [1:0] PC_JUMP   = 2'b11;

endpackage

// File: rtl/flash_fetch_byte_assembler.sv
// byte_assembler: collects the bytes of one instruction into a word.
//   clk, reset : clock and synchronous active-high reset
//   start      : clear all lanes (new fetch begins)
//   we, idx    : write din as byte number idx of the instruction
//   din        : byte from flash
//   word       : assembled instruction (registered lanes)
module byte_assembler
  import tau_pkg::*;
#(
  parameter int NBYTES        = 4,
  parameter bit LITTLE_ENDIAN = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    we,
  input  logic [$clog2(NBYTES)-1:0] idx,
  input  logic [7:0]              din,
  output logic [8*NBYTES-1:0]     word
);

  localparam int IDX_W = $clog2(NBYTES);

  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
    // Lane gi holds byte number POS of the instruction; big-endian mirrors the order.
    localparam int POS = LITTLE_ENDIAN ? gi : (NBYTES - 1 - gi);
    logic [7:0] lane_reg;

    always_ff @(posedge clk) begin
      if (reset || start) begin
        lane_reg <= '0;
      end else if (we && (idx == IDX_W'(POS))) begin
        lane_reg <= din;
      end
    end

    assign word[8*gi +: 8] = lane_reg;
  end

endmodule

// File: rtl/flash_fetch.sv
// flash_fetch: reads one instruction byte-by-byte from a flash with a
// one-cycle registered read and presents the assembled word.
//   clk, reset            : clock, synchronous active-high reset
//   req_valid/req_addr    : fetch request; req_ready high only when idle
//   flush                 : abort any in-flight fetch (highest priority)
//   flash_re/flash_addr   : flash read port; flash_out arrives one clock later
//   instr/instr_fault     : result, qualified by instr_valid
//   instr_ready           : consumer accepts the result
module flash_fetch
  import tau_pkg::*;
#(
  parameter int ADDR_W        = FLASH_ADDR_W,
  parameter int INSTR_BYTES   = tau_pkg::INSTR_BYTES,
  parameter bit LITTLE_ENDIAN = 1'b1,
  parameter bit ALIGN_CHECK   = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  input  logic [ADDR_W-1:0]        req_addr,
  output logic                     req_ready,
  input  logic                     flush,
  output logic                     flash_re,
  output logic [ADDR_W-1:0]        flash_addr,
  input  logic [7:0]               flash_out,
  output logic [8*INSTR_BYTES-1:0] instr,
  output logic                     instr_fault,
  output logic                     instr_valid,
  input  logic                     instr_ready
);

  localparam int OFF_W = $clog2(INSTR_BYTES);
  localparam int CNT_W = OFF_W + 1;

  fetch_state_t      state_reg, state_next;
  logic              req_ready_reg, req_ready_next;
  logic              flash_re_reg, flash_re_next;
  logic [ADDR_W-1:0] flash_addr_reg, flash_addr_next;
  logic              fault_reg, fault_next;
  logic              valid_reg, valid_next;
  logic [CNT_W-1:0]  iss_cnt_reg, iss_cnt_next;
  logic [OFF_W-1:0]  cap_cnt_reg, cap_cnt_next;
  logic              rd_pend_reg, rd_pend_next;
  logic              asm_start, asm_we;

  always_comb begin
    state_next      = state_reg;
    flash_re_next   = flash_re_reg;
    flash_addr_next = flash_addr_reg;
    fault_next      = fault_reg;
    valid_next      = valid_reg;
    iss_cnt_next    = iss_cnt_reg;
    cap_cnt_next    = cap_cnt_reg;
    // A read sampled by the flash on this edge delivers its byte on the next one.
    rd_pend_next    = flash_re_reg;
    asm_start       = 1'b0;
    asm_we          = 1'b0;

    if (flush) begin
      // Dropping rd_pend discards the byte still in flight.
      state_next      = IDLE;
      flash_re_next   = 1'b0;
      flash_addr_next = '0;
      valid_next      = 1'b0;
      fault_next      = 1'b0;
      rd_pend_next    = 1'b0;
    end else begin
      asm_we = rd_pend_reg;
      if (rd_pend_reg) begin
        cap_cnt_next = cap_cnt_reg + OFF_W'(1);
      end
      unique case (state_reg)
        IDLE: begin
          if (req_ready_reg && req_valid) begin
            asm_start    = 1'b1;
            cap_cnt_next = '0;
            if (ALIGN_CHECK && (req_addr[OFF_W-1:0] != '0)) begin
              state_next = HOLD;
              fault_next = 1'b1;
              valid_next = 1'b1;
            end else begin
              state_next      = ISSUE;
              fault_next      = 1'b0;
              flash_re_next   = 1'b1;
              flash_addr_next = req_addr;
              iss_cnt_next    = CNT_W'(1);
            end
          end
        end
        ISSUE: begin
          if (iss_cnt_reg == CNT_W'(INSTR_BYTES)) begin
            state_next      = DRAIN;
            flash_re_next   = 1'b0;
            flash_addr_next = '0;
          end else begin
            flash_addr_next = flash_addr_reg + ADDR_W'(1);
            iss_cnt_next    = iss_cnt_reg + CNT_W'(1);
          end
        end
        DRAIN: begin
          // The final byte is captured on this edge by asm_we.
          state_next = HOLD;
          valid_next = 1'b1;
        end
        HOLD: begin
          if (instr_ready) begin
            state_next = IDLE;
            valid_next = 1'b0;
            fault_next = 1'b0;
          end
        end
        default: state_next = IDLE;
      endcase
    end

    req_ready_next = (state_next == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      req_ready_reg  <= 1'b0;
      flash_re_reg   <= 1'b0;
      flash_addr_reg <= '0;
      fault_reg      <= 1'b0;
      valid_reg      <= 1'b0;
      iss_cnt_reg    <= '0;
      cap_cnt_reg    <= '0;
      rd_pend_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      req_ready_reg  <= req_ready_next;
      flash_re_reg   <= flash_re_next;
      flash_addr_reg <= flash_addr_next;
      fault_reg      <= fault_next;
      valid_reg      <= valid_next;
      iss_cnt_reg    <= iss_cnt_next;
      cap_cnt_reg    <= cap_cnt_next;
      rd_pend_reg    <= rd_pend_next;
    end
  end

  byte_assembler #(
    .NBYTES       (INSTR_BYTES),
    .LITTLE_ENDIAN(LITTLE_ENDIAN)
  ) u_asm (
    .clk  (clk),
    .reset(reset),
    .start(asm_start),
    .we   (asm_we),
    .idx  (cap_cnt_reg),
    .din  (flash_out),
    .word (instr)
  );

  assign req_ready   = req_ready_reg;
  assign flash_re    = flash_re_reg;
  assign flash_addr  = flash_addr_reg;
  assign instr_fault = fault_reg;
  assign instr_valid = valid_reg;

endmodule

// File: tb/tb_flash_fetch.sv
// Bench for flash_fetch. Three instances share the request side:
//   0: defaults, 1: LITTLE_ENDIAN=0, 2: ALIGN_CHECK=0.
module tb_flash_fetch;
  import tau_pkg::*;

  localparam int AW = 24;
  localparam int NB = 4;
  localparam int ND = 3;

  typedef struct packed {
    logic [8*NB-1:0] w;
    logic            f;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset, req_valid, flush, instr_ready;
  logic [AW-1:0] req_addr;

  logic            req_ready_w  [ND];
  logic            flash_re_w   [ND];
  logic [AW-1:0]   flash_addr_w [ND];
  logic [8*NB-1:0] instr_w      [ND];
  logic            fault_w      [ND];
  logic            valid_w      [ND];

  int total = 0;
  int bad   = 0;

  exp_t q0[$], q1[$], q2[$];
  int            vcyc [ND];
  int            nre  [ND];
  logic [AW-1:0] atr  [ND][8];

  always #5 clk = ~clk;

  function automatic logic [7:0] byte_at(input logic [AW-1:0] a);
    case (a)
      24'h000000: byte_at = 8'h93;
      24'h000001: byte_at = 8'h00;
      24'h000002: byte_at = 8'hA1;
      24'h000003: byte_at = 8'h00;
      default:    byte_at = a[7:0] ^ a[15:8] ^ 8'h5A;
    endcase
  endfunction

  for (genvar gi = 0; gi < ND; gi++) begin : g_dut
    logic [7:0] fo = 8'h00;
    always @(posedge clk) if (flash_re_w[gi]) fo <= byte_at(flash_addr_w[gi]);

    flash_fetch #(
      .LITTLE_ENDIAN((gi == 1) ? 1'b0 : 1'b1),
      .ALIGN_CHECK  ((gi == 2) ? 1'b0 : 1'b1)
    ) u_dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
      .req_ready(req_ready_w[gi]), .flush(flush), .flash_re(flash_re_w[gi]),
      .flash_addr(flash_addr_w[gi]), .flash_out(fo), .instr(instr_w[gi]),
      .instr_fault(fault_w[gi]), .instr_valid(valid_w[gi]), .instr_ready(instr_ready)
    );
  end

  // Reference: bytes at a..a+N-1 (mod 2^AW) placed by endianness, or a fault.
  function automatic exp_t model(input logic [AW-1:0] a, input int d);
    exp_t e;
    logic [AW-1:0] ba;
    e = '0;
    if (d != 2 && a[1:0] != 2'b00) begin
      e.f = 1'b1;
      return e;
    end
    for (int k = 0; k < NB; k++) begin
      ba = a + AW'(k);
      if (d == 1) e.w[8*(NB-1-k) +: 8] = byte_at(ba);
      else        e.w[8*k +: 8]        = byte_at(ba);
    end
    return e;
  endfunction

  function automatic void qpush(input int d, input exp_t e);
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic int qsize(input int d);
    case (d)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t qpop(input int d);
    case (d)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic compare_pop(input int d, input int j);
    exp_t e;
    e = qpop(d);
    chk($sformatf("instr_d%0d", d), 64'(instr_w[d]), 64'(e.w));
    chk($sformatf("fault_d%0d", d), 64'(fault_w[d]), 64'(e.f));
    vcyc[d] = j;
    $display("fetch d%0d cycle=%0d instr=%08h fault=%0b", d, j, instr_w[d], fault_w[d]);
  endtask

  // Issue one request, then watch every instance until each result is popped.
  task automatic run_fetch(input logic [AW-1:0] a, input int budget);
    for (int d = 0; d < ND; d++) begin
      qpush(d, model(a, d));
      vcyc[d] = -1;
      nre[d]  = 0;
    end
    req_addr  = a;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int j = 0; j < budget; j++) begin
      if (qsize(0) + qsize(1) + qsize(2) == 0) break;
      for (int d = 0; d < ND; d++) begin
        if (flash_re_w[d]) begin
          if (nre[d] < 8) atr[d][nre[d]] = flash_addr_w[d];
          nre[d]++;
        end
        if (valid_w[d] && qsize(d) > 0) compare_pop(d, j);
        else if (instr_ready) chk($sformatf("extra_valid_d%0d", d), 64'(valid_w[d]), 64'd0);
      end
      tick();
    end
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("timeout_d%0d", d), 64'(qsize(d)), 64'd0);
      while (qsize(d) > 0) void'(qpop(d));
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("%s_rdy_d%0d", tag, d),   64'(req_ready_w[d]),  64'd0);
      chk($sformatf("%s_re_d%0d", tag, d),    64'(flash_re_w[d]),   64'd0);
      chk($sformatf("%s_addr_d%0d", tag, d),  64'(flash_addr_w[d]), 64'd0);
      chk($sformatf("%s_instr_d%0d", tag, d), 64'(instr_w[d]),      64'd0);
      chk($sformatf("%s_fault_d%0d", tag, d), 64'(fault_w[d]),      64'd0);
      chk($sformatf("%s_valid_d%0d", tag, d), 64'(valid_w[d]),      64'd0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int            nrdy, v1, v2;
    logic          rdy;
    logic [15:0]   re_mask;
    exp_t          e;

    reset = 1'b1; req_valid = 1'b0; flush = 1'b0; instr_ready = 1'b0; req_addr = '0;
    tick(); tick();
    chk_reset_vals("reset");
    reset = 1'b0;
    tick();
    chk("ready_after_reset", 64'(req_ready_w[0]), 64'd1);

    // Basic fetch at 0 under backpressure.
    run_fetch(24'h000000, 20);
    chk("basic_nre", 64'(nre[0]), 64'd4);
    for (int k = 0; k < 4; k++) chk($sformatf("basic_addr%0d", k), 64'(atr[0][k]), 64'(k));
    chk("basic_latency", 64'(vcyc[0]), 64'd5);
    chk("basic_le_word", 64'(instr_w[0]), 64'h00A10093);
    chk("basic_be_word", 64'(instr_w[1]), 64'h9300A100);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("hold_instr", 64'(instr_w[0]), 64'h00A10093);
      chk("hold_valid", 64'(valid_w[0]), 64'd1);
      chk("hold_ready", 64'(req_ready_w[0]), 64'd0);
    end
    instr_ready = 1'b1;
    tick();
    chk("release_valid", 64'(valid_w[0]), 64'd0);
    chk("release_ready", 64'(req_ready_w[0]), 64'd1);

    // Misaligned: fault on checked instances, bytes 2..5 on the unchecked one.
    run_fetch(24'h000002, 20);
    chk("mis_latency", 64'(vcyc[0]), 64'd0);
    chk("mis_no_read", 64'(nre[0]), 64'd0);
    chk("mis_unchk_nre", 64'(nre[2]), 64'd4);

    // Address wrap on the unchecked instance.
    run_fetch(24'hFFFFFE, 20);
    chk("wrap_a0", 64'(atr[2][0]), 64'hFFFFFE);
    chk("wrap_a1", 64'(atr[2][1]), 64'hFFFFFF);
    chk("wrap_a2", 64'(atr[2][2]), 64'h000000);
    chk("wrap_a3", 64'(atr[2][3]), 64'h000001);

    // Flush on the second issue cycle.
    req_addr = 24'h000000; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    chk("flush_pre_addr", 64'(flash_addr_w[0]), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_re", 64'(flash_re_w[0]), 64'd0);
    chk("flush_ready", 64'(req_ready_w[0]), 64'd1);
    for (int i = 0; i < 6; i++) begin
      chk("flush_no_valid", 64'(valid_w[0]), 64'd0);
      tick();
    end
    run_fetch(24'h000004, 20);

    // Request together with flush is not accepted.
    req_addr = 24'h000000; req_valid = 1'b1; flush = 1'b1;
    tick();
    req_valid = 1'b0; flush = 1'b0;
    chk("flushreq_re", 64'(flash_re_w[0]), 64'd0);
    chk("flushreq_ready", 64'(req_ready_w[0]), 64'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("flushreq_no_valid", 64'(valid_w[0]), 64'd0);
    end

    // Reset in mid-fetch.
    req_addr = 24'h000000; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk_reset_vals("midreset");
    reset = 1'b0;
    tick();
    chk("midreset_ready", 64'(req_ready_w[0]), 64'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("midreset_no_valid", 64'(valid_w[0]), 64'd0);
    end
    run_fetch(24'h000004, 20);

    // Back-to-back fetches with instr_ready tied high.
    for (int d = 0; d < ND; d++) begin
      qpush(d, model(24'h000000, d));
      qpush(d, model(24'h000004, d));
    end
    req_addr = 24'h000000; req_valid = 1'b1;
    tick();
    req_addr = 24'h000004;
    nrdy = 0; v1 = -1; v2 = -1; re_mask = '0;
    for (int j = 0; j < 16; j++) begin
      re_mask[j] = flash_re_w[0];
      for (int d = 0; d < ND; d++) begin
        if (valid_w[d] && qsize(d) > 0) begin
          if (d == 0) begin
            if (v1 < 0) v1 = j;
            else v2 = j;
          end
          e = qpop(d);
          total++;
          assert (instr_w[d] === e.w && fault_w[d] === e.f) else begin
            bad++;
            $error("FAIL b2b_d%0d observed=%0h expected=%0h", d, instr_w[d], e.w);
          end
          $display("b2b d%0d cycle=%0d instr=%08h", d, j, instr_w[d]);
        end
      end
      rdy = req_ready_w[0];
      if (rdy && j < 12) nrdy++;
      tick();
      if (rdy) req_valid = 1'b0;
    end
    chk("b2b_first", 64'(v1), 64'd5);
    chk("b2b_second", 64'(v2), 64'd12);
    chk("b2b_re_windows", 64'(re_mask), 64'h078F);
    chk("b2b_idle_gap", 64'(nrdy), 64'd1);
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("b2b_left_d%0d", d), 64'(qsize(d)), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
